key_sequencer: RTL and testbench
================================

KEY_SEQUENCER -- requirements
Module: key_sequencer

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 20000, consecutive stable cycles required to accept a button level change.
REQ-002 SHALL have parameter AUTO_PERIOD, default 50000000, cycles between automatic advances in auto mode.
REQ-003 SHALL have parameter MAX_IDX, default 15, highest pattern index (range 1..15).
REQ-004 SHALL have parameter REPEAT_DELAY, default 25000000, hold cycles before the first auto-repeat step.
REQ-005 SHALL have parameter REPEAT_PERIOD, default 5000000, cycles between subsequent auto-repeat steps.
REQ-006 sysclk  input  1  single system clock; all logic on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 Bt_Next  input  1  raw asynchronous button, active-high: step pattern up.
REQ-009 Bt_Pre  input  1  raw asynchronous button, active-high: step pattern down.
REQ-010 Bt_Auto  input  1  raw asynchronous button, active-high: toggle auto mode.
REQ-011 Enable_SW  output  4  registered pattern index consumed by the pulse shaper.
REQ-012 Auto_Active  output  1  registered; high while in AUTO state.

Function
REQ-013 Each button SHALL pass through a 2-flop synchronizer before any other logic.
REQ-014 Per button, debounced level SHALL change only after the synchronized level differs from it for DEB_CYCLES consecutive cycles; any return to the debounced level clears that counter.
REQ-015 A debounced 0->1 transition SHALL produce a one-cycle press pulse; release produces nothing.
REQ-016 Enable_SW SHALL update on the cycle after the press pulse; total latency from first sysclk edge sampling a clean high = DEB_CYCLES + 4 cycles.
REQ-017 Next press: Enable_SW = Enable_SW+1, MAX_IDX wraps to 0.
REQ-018 Pre press: Enable_SW = Enable_SW-1, 0 wraps to MAX_IDX.
REQ-019 Next and Pre press pulses in the same cycle SHALL leave Enable_SW unchanged.
REQ-020 FSM states MANUAL and AUTO; Auto press toggles MANUAL<->AUTO; Auto_Active = (state==AUTO).
REQ-021 In AUTO, a tick counter SHALL advance Enable_SW as a Next step every AUTO_PERIOD cycles; counter clears on entering AUTO.
REQ-022 A manual Next/Pre step in AUTO SHALL apply and restart the tick counter; a tick coinciding with a manual step is discarded.
REQ-023 Auto press coinciding with Next/Pre SHALL both toggle state and apply the step.
REQ-024 Enable_SW SHALL never exceed MAX_IDX.

Reset
REQ-025 reset SHALL force Enable_SW=0, Auto_Active=0, state=MANUAL, synchronizers/debounced levels=0, all counters=0, no press pulses.
REQ-026 reset asserted mid-debounce or mid-period SHALL discard the partial count; a button held through reset release is re-debounced and then yields one press.

Configuration
REQ-027 With macro KEY_SEQ_REPEAT_EN defined, holding Next or Pre (debounced high) SHALL emit an extra step after REPEAT_DELAY cycles, then every REPEAT_PERIOD cycles until release; both held = no repeat.
REQ-028 Without KEY_SEQ_REPEAT_EN, a held button SHALL yield exactly one step; REPEAT_DELAY/REPEAT_PERIOD are unused and no repeat counters are synthesized.

Verification (DEB_CYCLES=4, AUTO_PERIOD=8, MAX_IDX=9, REPEAT_DELAY=20, REPEAT_PERIOD=6)
REQ-029 Bt_Next high 3 cycles then low -> Enable_SW stays 0 (bounce rejected); high 10 cycles -> Enable_SW 0->1 exactly 8 cycles after first high sample.
REQ-030 Enable_SW=9, one Next press -> 0; then one Pre press -> 9.
REQ-031 Bt_Next and Bt_Pre rising on the same cycle, held 10 cycles -> Enable_SW unchanged.
REQ-032 Auto press from Enable_SW=2 -> Auto_Active=1, Enable_SW=3 after 8 cycles, 4 after 16; second Auto press -> Auto_Active=0, counting stops.
REQ-033 reset pulsed 1 cycle with Enable_SW=5 in AUTO -> next cycle Enable_SW=0, Auto_Active=0.
REQ-034 With KEY_SEQ_REPEAT_EN, Bt_Next held 40 cycles from 0 -> Enable_SW 1, then 2 at +20 cycles, 3 at +26, 4 at +32; without the macro -> stays 1.

Source files
------------

// File: rtl/key_sequencer.sv
// Three-button pattern index sequencer with debounce, wrap and auto-advance.
// Define KEY_SEQ_REPEAT_EN to enable hold-to-repeat on Next/Pre.
module key_sequencer #(
  parameter int DEB_CYCLES    = 20000,
  parameter int AUTO_PERIOD   = 50000000,
  parameter int MAX_IDX       = 15,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       Bt_Next,
  input  logic       Bt_Pre,
  input  logic       Bt_Auto,
  output logic [3:0] Enable_SW,
  output logic       Auto_Active
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int TW = $clog2(AUTO_PERIOD + 1);
  localparam logic [3:0] MAX = 4'(MAX_IDX);

  typedef enum logic {MANUAL, AUTO} state_t;

  state_t        state, state_nxt;
  logic [2:0]    raw, sync1, sync2;
  logic [2:0]    deb, deb_d, press;
  logic [DW-1:0] deb_cnt [3];
  logic [TW-1:0] tick_cnt;
  logic          nxt_p, pre_p, auto_p;
  logic          rep_up, rep_dn;
  logic          n_req, p_req;
  logic          up, dn, manual, tick_due, tick;

  assign raw = {Bt_Auto, Bt_Pre, Bt_Next};

  // bit 0 Next, bit 1 Pre, bit 2 Auto
  always_ff @(posedge sysclk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_d <= '0;
      press <= '0;
      for (int i = 0; i < 3; i++)
        deb_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_d <= deb;
      press <= deb & ~deb_d;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DW'(DEB_CYCLES)) begin
          deb[i]     <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign nxt_p  = press[0];
  assign pre_p  = press[1];
  assign auto_p = press[2];

`ifdef KEY_SEQ_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                        REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = $clog2(RMAX + 1);

  logic [RW-1:0] rep_cnt;
  logic          rep_first;
  logic          held;
  logic          rep_fire;

  // exactly one of Next/Pre held; counter arms on its press
  assign held     = deb[0] ^ deb[1];
  assign rep_fire = held && (rep_cnt == (rep_first ?
                    RW'(REPEAT_DELAY) : RW'(REPEAT_PERIOD)));

  always_ff @(posedge sysclk) begin
    if (reset || !held) begin
      rep_cnt   <= '0;
      rep_first <= 1'b1;
    end else if (nxt_p || pre_p) begin
      rep_cnt   <= RW'(1);
      rep_first <= 1'b1;
    end else if (rep_fire) begin
      rep_cnt   <= RW'(1);
      rep_first <= 1'b0;
    end else if (rep_cnt != '0) begin
      rep_cnt <= rep_cnt + 1'b1;
    end
  end

  assign rep_up = rep_fire & deb[0];
  assign rep_dn = rep_fire & deb[1];
`else
  // repeat timing parameters carry no logic in this build
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_no_repeat
  end

  assign rep_up = 1'b0;
  assign rep_dn = 1'b0;
`endif

  assign n_req    = nxt_p | rep_up;
  assign p_req    = pre_p | rep_dn;
  assign up       = n_req & ~p_req;
  assign dn       = p_req & ~n_req;
  assign manual   = up | dn;
  assign tick_due = (state == AUTO) &&
                    (tick_cnt == TW'(AUTO_PERIOD - 1));
  assign tick     = tick_due & ~manual;

  always_ff @(posedge sysclk) begin
    if (reset)
      state <= MANUAL;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      auto_p && state == MANUAL: state_nxt = AUTO;
      auto_p && state == AUTO:   state_nxt = MANUAL;
      default:                   state_nxt = state;
    endcase
  end

  always_comb begin
    Auto_Active = (state == AUTO);
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      Enable_SW <= '0;
      tick_cnt  <= '0;
    end else begin
      if (up || tick)
        Enable_SW <= (Enable_SW >= MAX) ? 4'd0 : Enable_SW + 4'd1;
      else if (dn)
        Enable_SW <= (Enable_SW == 4'd0) ? MAX : Enable_SW - 4'd1;
      // a manual step or a state change restarts the period
      if (state != AUTO || auto_p || manual || tick_due)
        tick_cnt <= '0;
      else
        tick_cnt <= tick_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_key_sequencer.sv
// Scoreboard bench for key_sequencer: stimulus queues expected output
// changes with their cycle, a negedge monitor pops and compares them.
module tb_key_sequencer;

  localparam int MAXI = 9;

  logic       sysclk = 1'b0;
  logic       reset;
  logic       Bt_Next, Bt_Pre, Bt_Auto;
  logic [3:0] Enable_SW;
  logic       Auto_Active;

  key_sequencer #(
    .DEB_CYCLES   (4),
    .AUTO_PERIOD  (8),
    .MAX_IDX      (MAXI),
    .REPEAT_DELAY (20),
    .REPEAT_PERIOD(6)
  ) dut (
    .sysclk     (sysclk),
    .reset      (reset),
    .Bt_Next    (Bt_Next),
    .Bt_Pre     (Bt_Pre),
    .Bt_Auto    (Bt_Auto),
    .Enable_SW  (Enable_SW),
    .Auto_Active(Auto_Active)
  );

  always #5 sysclk = ~sysclk;

  typedef struct {
    int         cyc;
    logic [3:0] en;
    logic       act;
  } exp_t;

  exp_t       q[$];
  int         cyc = 0;
  int         vectors = 0;
  int         errors = 0;
  bit         mon_on = 1'b0;
  logic [4:0] last;
  int         en = 0;
  logic       act = 1'b0;

  always @(posedge sysclk) cyc <= cyc + 1;

  always @(negedge sysclk) begin
    if (mon_on) begin
      if ({Auto_Active, Enable_SW} != last) begin
        last = {Auto_Active, Enable_SW};
        vectors++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change cyc=%0d got en=%0d act=%0b",
                   cyc, Enable_SW, Auto_Active);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (e.cyc != cyc || e.en != Enable_SW || e.act != Auto_Active) begin
            errors++;
            $display("FAIL change got cyc=%0d en=%0d act=%0b want cyc=%0d en=%0d act=%0b",
                     cyc, Enable_SW, Auto_Active, e.cyc, e.en, e.act);
          end
        end
      end
      if (q.size() != 0 && cyc > q[0].cyc) begin
        exp_t m;
        m = q.pop_front();
        vectors++;
        errors++;
        $display("FAIL missing_change got cyc=%0d en=%0d act=%0b want cyc=%0d en=%0d act=%0b",
                 cyc, Enable_SW, Auto_Active, m.cyc, m.en, m.act);
      end
    end
  end

  function automatic int inc(input int v);
    return (v == MAXI) ? 0 : v + 1;
  endfunction

  function automatic int dec(input int v);
    return (v == 0) ? MAXI : v - 1;
  endfunction

  task automatic chk(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic pulse(input logic [2:0] m, input int hold, input int gap);
    {Bt_Auto, Bt_Pre, Bt_Next} = m;
    repeat (hold) @(negedge sysclk);
    {Bt_Auto, Bt_Pre, Bt_Next} = 3'b000;
    repeat (gap) @(negedge sysclk);
  endtask

  task automatic step_next();
    en = inc(en);
    q.push_back('{cyc + 9, 4'(en), act});
    pulse(3'b001, 10, 12);
  endtask

  task automatic step_pre();
    en = dec(en);
    q.push_back('{cyc + 9, 4'(en), act});
    pulse(3'b010, 10, 12);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d queue=%0d", cyc, q.size());
    $fatal(1);
  end

  initial begin
    int c;
    reset = 1'b1;
    {Bt_Auto, Bt_Pre, Bt_Next} = 3'b000;
    repeat (3) @(negedge sysclk);
    reset = 1'b0;
    @(negedge sysclk);
    chk("reset_en", int'(Enable_SW), 0);
    chk("reset_act", int'(Auto_Active), 0);
    last = {Auto_Active, Enable_SW};
    mon_on = 1'b1;

    pulse(3'b001, 3, 12);
    chk("bounce_en", int'(Enable_SW), 0);

    step_next();
    repeat (8) step_next();
    chk("at_max", int'(Enable_SW), 9);
    step_next();
    chk("wrap_up", int'(Enable_SW), 0);
    step_pre();
    chk("wrap_down", int'(Enable_SW), 9);

    pulse(3'b011, 10, 12);
    chk("both_en", int'(Enable_SW), 9);

    repeat (7) step_pre();
    chk("pre_to_2", int'(Enable_SW), 2);

    c = cyc;
    act = 1'b1;
    q.push_back('{c + 9, 4'(en), 1'b1});
    q.push_back('{c + 17, 4'(en + 1), 1'b1});
    q.push_back('{c + 25, 4'(en + 2), 1'b1});
    en = en + 2;
    pulse(3'b100, 10, 10);
    act = 1'b0;
    q.push_back('{cyc + 9, 4'(en), 1'b0});
    pulse(3'b100, 10, 12);
    chk("auto_off_en", int'(Enable_SW), 4);
    chk("auto_off_act", int'(Auto_Active), 0);

    step_next();
    c = cyc;
    act = 1'b1;
    q.push_back('{c + 9, 4'(en), 1'b1});
    pulse(3'b100, 10, 2);
    reset = 1'b1;
    en = 0;
    act = 1'b0;
    q.push_back('{cyc + 1, 4'd0, 1'b0});
    @(negedge sysclk);
    reset = 1'b0;
    repeat (12) @(negedge sysclk);
    chk("rst_mid_en", int'(Enable_SW), 0);
    chk("rst_mid_act", int'(Auto_Active), 0);

    reset = 1'b1;
    Bt_Next = 1'b1;
    repeat (3) @(negedge sysclk);
    reset = 1'b0;
    en = 1;
    q.push_back('{cyc + 9, 4'd1, 1'b0});
    repeat (15) @(negedge sysclk);
    Bt_Next = 1'b0;
    repeat (12) @(negedge sysclk);
    chk("held_thru_rst", int'(Enable_SW), 1);

    step_pre();
    c = cyc;
    en = 1;
    q.push_back('{c + 9, 4'd1, 1'b0});
`ifdef KEY_SEQ_REPEAT_EN
    q.push_back('{c + 29, 4'd2, 1'b0});
    q.push_back('{c + 35, 4'd3, 1'b0});
    q.push_back('{c + 41, 4'd4, 1'b0});
    en = 4;
`endif
    pulse(3'b001, 36, 14);
    chk("hold_result", int'(Enable_SW), en);

    repeat (10) @(negedge sysclk);
    chk("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
